// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control decoder: ALUop classes,
// LEGv8 opcode patterns, base ALU control codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  // I-type forms are matched on Opcode[10:1]; bit 0 belongs to the immediate.
  localparam logic [9:0] OPC_ADDI = 10'b1001000100;
  localparam logic [9:0] OPC_SUBI = 10'b1101000100;
  localparam logic [9:0] OPC_ANDI = 10'b1001001000;
  localparam logic [9:0] OPC_ORRI = 10'b1011001000;

  localparam logic [3:0] CODE_AND  = 4'b0000;
  localparam logic [3:0] CODE_ORR  = 4'b0001;
  localparam logic [3:0] CODE_ADD  = 4'b0010;
  localparam logic [3:0] CODE_LSL  = 4'b0011;
  localparam logic [3:0] CODE_LSR  = 4'b0100;
  localparam logic [3:0] CODE_SUB  = 4'b0110;
  localparam logic [3:0] CODE_PASS = 4'b0111;
  localparam logic [3:0] CODE_MUL  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_MULW = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational {ALUop, Opcode} -> {ALU control code, is_mul, illegal}.
// Undecodable ops return an all-ones code so they cannot alias a real operation.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        alu_op,
  input  logic [10:0]       opcode,
  output logic [CTRL_W-1:0] code,
  output logic              is_mul,
  output logic              illegal
);

  logic [3:0] base;

  always_comb begin
    base    = CODE_AND;
    is_mul  = 1'b0;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_LDST: base = CODE_ADD;
      ALUOP_CBZ:  base = CODE_PASS;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_SUB: base = CODE_SUB;
          OPC_ORR: base = CODE_ORR;
          OPC_AND: base = CODE_AND;
          OPC_ADD: base = CODE_ADD;
          OPC_LSL: base = CODE_LSL;
          OPC_LSR: base = CODE_LSR;
          OPC_MUL: begin
            base   = CODE_MUL;
            is_mul = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_ITYPE: begin
        case (opcode[10:1])
          OPC_ADDI: base = CODE_ADD;
          OPC_SUBI: base = CODE_SUB;
          OPC_ANDI: base = CODE_AND;
          OPC_ORRI: base = CODE_ORR;
          default:  illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    code = illegal ? {CTRL_W{1'b1}} : CTRL_W'(base);
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control stage: decodes the op, holds the result
// until the consumer takes it, paces MUL latency and counts delivered illegal ops.
//
// state   | meaning
// ST_IDLE | no output pending, ready for a new op
// ST_HOLD | decoded op presented (out_valid), waiting for out_ready
// ST_MULW | MUL accepted, counting down to its result slot
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int ERR_W      = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUop,
  input  logic [10:0]       Opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              is_mul,
  output logic              illegal,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic               is_mul_q, is_mul_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [CTRL_W-1:0]  dec_code;
  logic               dec_is_mul;
  logic               dec_illegal;
  logic               accept;

  alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .alu_op  (ALUop),
    .opcode  (Opcode),
    .code    (dec_code),
    .is_mul  (dec_is_mul),
    .illegal (dec_illegal)
  );

  assign in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    is_mul_d    = is_mul_q;
    illegal_d   = illegal_q;
    busy_d      = busy_q;
    err_cnt_d   = err_cnt_q;

    if (flush) begin
      // ALUCtrl deliberately keeps its last value; only the qualifiers drop.
      state_d     = ST_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      is_mul_d    = 1'b0;
      illegal_d   = 1'b0;
      busy_d      = 1'b0;
    end else begin
      if (out_valid_q && out_ready && illegal_q && (err_cnt_q != {ERR_W{1'b1}}))
        err_cnt_d = err_cnt_q + ERR_W'(1);

      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            alu_ctrl_d = dec_code;
            is_mul_d   = dec_is_mul;
            illegal_d  = dec_illegal;
            if (dec_is_mul) begin
              state_d     = ST_MULW;
              cnt_d       = CNT_LOAD;
              busy_d      = 1'b1;
              out_valid_d = 1'b0;
            end else begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end
          end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        ST_MULW: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      is_mul_q    <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      is_mul_q    <= is_mul_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALUCtrl   = alu_ctrl_q;
  assign is_mul    = is_mul_q;
  assign illegal   = illegal_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq with hand-computed expectations.
module tb_alu_control_seq;

  logic        CLK = 1'b0;
  logic        Reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  ALUop;
  logic [10:0] Opcode;
  logic [3:0]  ALUCtrl;
  logic        is_mul, illegal, busy;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alu_control_seq #(.CTRL_W(4), .MUL_CYCLES(4), .ERR_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .Opcode(Opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUCtrl(ALUCtrl), .is_mul(is_mul), .illegal(illegal),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc);
    in_valid = v;
    ALUop    = op;
    Opcode   = opc;
  endtask

  // Back-to-back decode table: {ALUop, Opcode, expected code}
  logic [1:0]  tab_op  [7] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11};
  logic [10:0] tab_opc [7] = '{11'b11010011011, 11'b11010011010, 11'b11010001000,
                               11'b10010010001, 11'b10110010000, 11'b00000000000,
                               11'b11111111111};
  logic [3:0]  tab_exp [7] = '{4'h3, 4'h4, 4'h6, 4'h0, 4'h1, 4'h7, 4'hF};

  initial begin
    Reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 2'b00, 11'h0);
    tick(); tick();
    chk_val("rst_out_valid", out_valid, 0);
    chk_val("rst_aluctrl", ALUCtrl, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_err_cnt", err_cnt, 0);
    Reset = 1'b0;

    // SUB, then back-to-back AND, ORR, LDUR
    drive(1'b1, 2'b10, 11'b11001011000);
    #1 chk_val("idle_in_ready", in_ready, 1);
    tick();
    chk_val("sub_valid", out_valid, 1);
    chk_val("sub_code", ALUCtrl, 4'b0110);
    drive(1'b1, 2'b10, 11'b10001010000);
    tick(); chk_val("and_code", ALUCtrl, 4'b0000); chk_val("and_valid", out_valid, 1);
    drive(1'b1, 2'b10, 11'b10101010000);
    tick(); chk_val("orr_code", ALUCtrl, 4'b0001);
    drive(1'b1, 2'b00, 11'b11111000010);
    tick(); chk_val("ldur_code", ALUCtrl, 4'b0010); chk_val("ldur_illegal", illegal, 0);
    drive(1'b0, 2'b00, 11'h0);
    tick(); chk_val("drain_valid", out_valid, 0);

    // Decode table streamed back-to-back
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tab_op[i], tab_opc[i]);
      tick();
      chk_val($sformatf("tab%0d_code", i), ALUCtrl, tab_exp[i]);
      chk_val($sformatf("tab%0d_illegal", i), illegal, (tab_exp[i] == 4'hF) ? 1 : 0);
    end
    drive(1'b0, 2'b00, 11'h0);
    tick();
    chk_val("tab_err_cnt", err_cnt, 1);

    // MUL latency: accepted in cycle t, busy t+1..t+3, result at t+4
    drive(1'b1, 2'b10, 11'b10011011000);
    tick();
    drive(1'b1, 2'b10, 11'b10101010000);
    #1;
    chk_val("mul_t1_busy", busy, 1);
    chk_val("mul_t1_in_ready", in_ready, 0);
    chk_val("mul_t1_valid", out_valid, 0);
    tick(); chk_val("mul_t2_busy", busy, 1); chk_val("mul_t2_valid", out_valid, 0);
    drive(1'b0, 2'b00, 11'h0);
    tick(); chk_val("mul_t3_busy", busy, 1); chk_val("mul_t3_in_ready", in_ready, 0);
    tick();
    chk_val("mul_t4_valid", out_valid, 1);
    chk_val("mul_t4_is_mul", is_mul, 1);
    chk_val("mul_t4_code", ALUCtrl, 4'b1000);
    chk_val("mul_t4_busy", busy, 0);
    tick(); chk_val("mul_done_valid", out_valid, 0);

    // ADDI stalled by out_ready=0 for 3 cycles; a new op must be ignored
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 11'b10010001001);
    tick();
    drive(1'b1, 2'b10, 11'b11001011000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_val($sformatf("stall%0d_code", i), ALUCtrl, 4'b0010);
      chk_val($sformatf("stall%0d_valid", i), out_valid, 1);
      chk_val($sformatf("stall%0d_in_ready", i), in_ready, 0);
      if (i < 2) tick();
    end
    drive(1'b0, 2'b00, 11'h0);
    out_ready = 1'b1;
    tick();
    chk_val("release_valid", out_valid, 0);
    chk_val("release_in_ready", in_ready, 1);

    // 300 illegal ops back-to-back; err_cnt already holds 1 from the table
    drive(1'b1, 2'b10, 11'b00000000000);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 1) begin
        chk_val("ill_first_code", ALUCtrl, 4'hF);
        chk_val("ill_first_flag", illegal, 1);
        chk_val("ill_first_cnt", err_cnt, 1);
      end
      if (i == 2)   chk_val("ill_cnt_2", err_cnt, 2);
      if (i == 100) chk_val("ill_cnt_100", err_cnt, 100);
      if (i == 254) chk_val("ill_cnt_254", err_cnt, 254);
      if (i == 255) chk_val("ill_cnt_255", err_cnt, 255);
      if (i == 256) chk_val("ill_cnt_sat", err_cnt, 255);
    end
    drive(1'b0, 2'b00, 11'h0);
    tick(); tick();
    chk_val("ill_cnt_end", err_cnt, 255);

    // Flush two cycles into a MUL
    drive(1'b1, 2'b10, 11'b10011011000);
    tick();
    drive(1'b0, 2'b00, 11'h0);
    tick();
    flush = 1'b1;
    #1 chk_val("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk_val("flush_busy", busy, 0);
    chk_val("flush_valid", out_valid, 0);
    chk_val("flush_is_mul", is_mul, 0);
    chk_val("flush_err_kept", err_cnt, 255);
    tick(); chk_val("flush_t4_valid", out_valid, 0);
    tick(); chk_val("flush_t5_valid", out_valid, 0);

    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    drive(1'b1, 2'b10, 11'b10001011000);
    #1 chk_val("flush_idle_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk_val("flush_idle_valid", out_valid, 0);

    // Reset during HOLD
    tick();
    chk_val("hold_add_code", ALUCtrl, 4'b0010);
    chk_val("hold_add_valid", out_valid, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b0, 2'b00, 11'h0);
    chk_val("rst2_valid", out_valid, 0);
    chk_val("rst2_code", ALUCtrl, 0);
    chk_val("rst2_illegal", illegal, 0);
    chk_val("rst2_is_mul", is_mul, 0);
    chk_val("rst2_busy", busy, 0);
    chk_val("rst2_err_cnt", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
